// File: rtl/axis_check_pkg.sv
// ============================================================================
//  Module      : axis_check_pkg
//  Description : Shared types and constants for the AXI-stream MISR checker:
//                checker state encoding, default MISR polynomial/seed and the
//                optional backpressure LFSR taps/seed.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_check_pkg;

  // Checker state: folding beats, discarding overlong tail, one-cycle report
  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    DRAIN  = 2'd1,
    REPORT = 2'd2
  } chk_state_e;

  localparam logic [63:0] DEFAULT_POLY = 64'h0000_0000_0000_001B;
  localparam logic [63:0] DEFAULT_SEED = 64'h0;

  // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci LFSR: feedback is the
  // XOR of bits 0,2,3,5, shifted in at bit 15.
  localparam logic [15:0] BP_LFSR_TAPS = 16'h002D;
  localparam logic [15:0] BP_LFSR_SEED = 16'hACE1;

endpackage

`default_nettype wire

// File: rtl/axis_if.sv
// ============================================================================
//  Module      : axis_if
//  Description : Minimal AXI-stream interface (tdata/tvalid/tready/tlast).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axis_if #(
  parameter int DW = 64
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

`default_nettype wire

// File: rtl/misr_step.sv
// ============================================================================
//  Module      : misr_step
//  Description : Combinational MISR update: shift left, conditional feedback
//                with POLY on the outgoing MSB, XOR in zero-extended data.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module misr_step #(
  parameter int SIG_W = 64,
  parameter int DW    = 64
) (
  input  logic [SIG_W-1:0] acc,
  input  logic [DW-1:0]    tdata,
  input  logic [SIG_W-1:0] poly,
  output logic [SIG_W-1:0] acc_next
);

  // One signature step for a single input word
  always_comb begin
    acc_next = {acc[SIG_W-2:0], 1'b0} ^ (acc[SIG_W-1] ? poly : '0) ^ SIG_W'(tdata);
  end

endmodule

`default_nettype wire

// File: rtl/axis_misr_checker.sv
// ============================================================================
//  Module      : axis_misr_checker
//  Description : AXI-stream sink that folds each N-beat packet into a MISR,
//                checks framing (tlast position) and compares the signature
//                to a golden value. Reports one pulse per packet, a sticky
//                error flag and a packet counter.
//  Options     : MISR_BACKPRESSURE_EN - gate tready with a free-running LFSR
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_misr_checker
  import axis_check_pkg::*;
#(
  parameter int               N     = 16,
  parameter int               DW    = 64,
  parameter int               SIG_W = 64,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             arstn,
  axis_if.slave            stream_in,
  input  logic [SIG_W-1:0] expected_sig,
  output logic [SIG_W-1:0] sig,
  output logic             sig_valid,
  output logic             sig_err,
  output logic             len_err,
  output logic             err_sticky,
  output logic [31:0]      pkt_cnt
);

  localparam int            CW       = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  chk_state_e       state_q, state_d;
  logic [SIG_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
  logic             rdy_en_q;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic             sig_valid_q, sig_valid_d;
  logic             sig_err_q, sig_err_d;
  logic             len_err_q, len_err_d;
  logic             err_sticky_q, err_sticky_d;
  logic [31:0]      pkt_cnt_q, pkt_cnt_d;

  logic [SIG_W-1:0] acc_next;
  logic             bp_ok;
  logic             beat;
  logic             finish;
  logic [SIG_W-1:0] fin_sig;
  logic             fin_len;

  misr_step #(
    .SIG_W (SIG_W),
    .DW    (DW)
  ) u_misr_step (
    .acc      (acc_q),
    .tdata    (stream_in.tdata),
    .poly     (POLY),
    .acc_next (acc_next)
  );

`ifdef MISR_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Free-running LFSR advance; bit 0 throttles tready
  always_comb begin
    lfsr_d = {^(lfsr_q & BP_LFSR_TAPS), lfsr_q[15:1]};
  end

  // LFSR state register
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) lfsr_q <= BP_LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign bp_ok = lfsr_q[0];
`else
  assign bp_ok = 1'b1;
`endif

  // rdy_en_q keeps tready low through reset and purely flop-driven afterwards;
  // REPORT is a mandatory bubble.
  assign stream_in.tready = rdy_en_q && (state_q != REPORT) && bp_ok;
  assign beat             = stream_in.tvalid && stream_in.tready;

  // Next-state, signature folding and report generation
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    beat_cnt_d   = beat_cnt_q;
    sig_d        = sig_q;
    sig_valid_d  = 1'b0;
    sig_err_d    = 1'b0;
    len_err_d    = 1'b0;
    err_sticky_d = err_sticky_q;
    pkt_cnt_d    = pkt_cnt_q;
    finish       = 1'b0;
    fin_sig      = acc_q;
    fin_len      = 1'b0;

    case (state_q)
      ACCEPT: begin
        if (beat) begin
          acc_d = acc_next;
          if (stream_in.tlast) begin
            finish  = 1'b1;
            fin_sig = acc_next;
            fin_len = (beat_cnt_q != LAST_IDX);
          end else if (beat_cnt_q == LAST_IDX) begin
            // Packet is overlong; being in DRAIN is the pending length error
            state_d = DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (beat && stream_in.tlast) begin
          finish  = 1'b1;
          fin_sig = acc_q;
          fin_len = 1'b1;
        end
      end
      REPORT: begin
        acc_d      = SEED;
        beat_cnt_d = '0;
        state_d    = ACCEPT;
      end
      default: begin
        state_d = ACCEPT;
      end
    endcase

    // Outputs are registered on the terminating beat so they are visible
    // during the REPORT cycle, one cycle after that beat.
    if (finish) begin
      state_d      = REPORT;
      sig_d        = fin_sig;
      sig_valid_d  = 1'b1;
      sig_err_d    = (fin_sig != expected_sig);
      len_err_d    = fin_len;
      err_sticky_d = err_sticky_q | sig_err_d | len_err_d;
      pkt_cnt_d    = pkt_cnt_q + 32'd1;
    end
  end

  // State, accumulator and report registers
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q      <= ACCEPT;
      acc_q        <= SEED;
      beat_cnt_q   <= '0;
      rdy_en_q     <= 1'b0;
      sig_q        <= '0;
      sig_valid_q  <= 1'b0;
      sig_err_q    <= 1'b0;
      len_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      pkt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      beat_cnt_q   <= beat_cnt_d;
      rdy_en_q     <= 1'b1;
      sig_q        <= sig_d;
      sig_valid_q  <= sig_valid_d;
      sig_err_q    <= sig_err_d;
      len_err_q    <= len_err_d;
      err_sticky_q <= err_sticky_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

  assign sig        = sig_q;
  assign sig_valid  = sig_valid_q;
  assign sig_err    = sig_err_q;
  assign len_err    = len_err_q;
  assign err_sticky = err_sticky_q;
  assign pkt_cnt    = pkt_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_misr_checker.sv
// ============================================================================
//  Module      : tb_axis_misr_checker
//  Description : Scoreboard bench for axis_misr_checker. Three checkers
//                (N=2, N=4, N=16) share one stream driver; only the selected
//                one sees tvalid. Expected reports are queued when the
//                terminating beat is issued and popped by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_misr_checker;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  int          sel = 0;
  logic [63:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic [63:0] exp_sig = '0;

  logic [2:0][63:0] sig_o;
  logic [2:0]       sv, se, le, es;
  logic [2:0][31:0] pc;
  logic [2:0]       prev_sv = '0;
  logic             tr;

  always #5 clk = ~clk;

  axis_if #(.DW(64)) if2 ();
  axis_if #(.DW(64)) if4 ();
  axis_if #(.DW(64)) if16 ();

  assign if2.tdata  = tdata;  assign if2.tlast  = tlast;  assign if2.tvalid  = tvalid && (sel == 0);
  assign if4.tdata  = tdata;  assign if4.tlast  = tlast;  assign if4.tvalid  = tvalid && (sel == 1);
  assign if16.tdata = tdata;  assign if16.tlast = tlast;  assign if16.tvalid = tvalid && (sel == 2);
  assign tr = (sel == 0) ? if2.tready : (sel == 1) ? if4.tready : if16.tready;

  axis_misr_checker #(.N(2)) u_n2 (
    .clk(clk), .arstn(arstn), .stream_in(if2), .expected_sig(exp_sig),
    .sig(sig_o[0]), .sig_valid(sv[0]), .sig_err(se[0]), .len_err(le[0]),
    .err_sticky(es[0]), .pkt_cnt(pc[0]));

  axis_misr_checker #(.N(4)) u_n4 (
    .clk(clk), .arstn(arstn), .stream_in(if4), .expected_sig(exp_sig),
    .sig(sig_o[1]), .sig_valid(sv[1]), .sig_err(se[1]), .len_err(le[1]),
    .err_sticky(es[1]), .pkt_cnt(pc[1]));

  axis_misr_checker #(.N(16)) u_n16 (
    .clk(clk), .arstn(arstn), .stream_in(if16), .expected_sig(exp_sig),
    .sig(sig_o[2]), .sig_valid(sv[2]), .sig_err(se[2]), .len_err(le[2]),
    .err_sticky(es[2]), .pkt_cnt(pc[2]));

  typedef struct {
    int          dut;
    logic [63:0] sig;
    logic        serr;
    logic        lerr;
    logic        sticky;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          stalls = 0;
  logic [31:0] exp_cnt[3];
  logic        exp_sticky[3];

  function automatic logic [63:0] misr_ref(input logic [63:0] a, input logic [63:0] d);
    return {a[62:0], 1'b0} ^ (a[63] ? 64'h1B : 64'h0) ^ d;
  endfunction

  function automatic logic [63:0] pat(input int p, input int i);
    logic [63:0] k;
    k = 64'h9E37_79B9_7F4A_7C15;
    return k * 64'(p * 16 + i + 1);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push(input int dut, input logic [63:0] s, input logic serr, input logic lerr);
    exp_t e;
    exp_cnt[dut]    = exp_cnt[dut] + 32'd1;
    exp_sticky[dut] = exp_sticky[dut] | serr | lerr;
    e.dut = dut; e.sig = s; e.serr = serr; e.lerr = lerr;
    e.sticky = exp_sticky[dut]; e.cnt = exp_cnt[dut];
    sb.push_back(e);
  endtask

  // Present one beat at a negedge; return at the negedge after it is taken
  task automatic beat(input logic [63:0] d, input logic l, input logic [63:0] e);
    int n;
    n = 0;
    tdata = d; tlast = l; exp_sig = e; tvalid = 1'b1;
    while (!tr && n < 50) begin
      stalls++; n++;
      @(negedge clk);
    end
    if (!tr) begin
      check("beat_timeout", 64'(tr), 64'h1);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    tvalid = 1'b0; tlast = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      check({tag, "_sig"},    sig_o[k], 64'h0);
      check({tag, "_flags"},  64'({sv[k], se[k], le[k], es[k]}), 64'h0);
      check({tag, "_pktcnt"}, 64'(pc[k]), 64'h0);
    end
    check({tag, "_tready"}, 64'({if2.tready, if4.tready, if16.tready}), 64'h0);
  endtask

  // Monitor: pop and compare on every report pulse
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (sv[k]) begin
        check("valid_pulse_width", 64'(prev_sv[k]), 64'h0);
        if (sb.size() == 0) begin
          check("unexpected_report", 64'(k), 64'hFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("report_dut", 64'(k),     64'(e.dut));
          check("sig",        sig_o[k],   e.sig);
          check("sig_err",    64'(se[k]), 64'(e.serr));
          check("len_err",    64'(le[k]), 64'(e.lerr));
          check("err_sticky", 64'(es[k]), 64'(e.sticky));
          check("pkt_cnt",    64'(pc[k]), 64'(e.cnt));
        end
      end else if (se[k] || le[k]) begin
        check("err_without_valid", 64'({se[k], le[k]}), 64'h0);
      end
    end
    prev_sv <= sv;
  end

  initial begin
    logic [63:0] acc;
    logic [63:0] d;
    int          w;

    for (int k = 0; k < 3; k++) begin exp_cnt[k] = '0; exp_sticky[k] = 1'b0; end

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    arstn = 1'b1;
    @(negedge clk);
    check("tready_after_reset", 64'({if2.tready, if4.tready, if16.tready}), 64'h7);

    // N=2: 1,2 -> 0, clean
    sel = 0;
    beat(64'h1, 1'b0, 64'h0);
    push(0, 64'h0, 1'b0, 1'b0);
    beat(64'h2, 1'b1, 64'h0);
    // N=2: MSB feedback -> POLY, mismatch against 0
    beat(64'h8000_0000_0000_0000, 1'b0, 64'h0);
    push(0, 64'h1B, 1'b1, 1'b0);
    beat(64'h0, 1'b1, 64'h0);
    idle(3);
    check("sticky_holds", 64'(es[0]), 64'h1);
    // N=2: 1,5 -> 7, clean, sticky stays set
    beat(64'h1, 1'b0, 64'h7);
    push(0, 64'h7, 1'b0, 1'b0);
    beat(64'h5, 1'b1, 64'h7);
    idle(2);

    // N=4: short packet 3,5 -> 3 with len_err
    sel = 1;
    beat(64'h3, 1'b0, 64'h3);
    push(1, 64'h3, 1'b0, 1'b1);
    beat(64'h5, 1'b1, 64'h3);
    idle(1);
    // N=4: clean packet 1,2,3,4 -> 2
    beat(64'h1, 1'b0, 64'h2);
    beat(64'h2, 1'b0, 64'h2);
    beat(64'h3, 1'b0, 64'h2);
    push(1, 64'h2, 1'b0, 1'b0);
    beat(64'h4, 1'b1, 64'h2);
    idle(1);
    // N=4: 6 beats; only first 4 folded -> F; golden only valid on tlast beat
    for (int i = 0; i < 4; i++) beat(64'h1, 1'b0, 64'h55);
    beat(64'h7, 1'b0, 64'h55);
    push(1, 64'hF, 1'b0, 1'b1);
    beat(64'h9, 1'b1, 64'hF);
    idle(2);

    // N=16: 8 back-to-back packets, tvalid held high; packet 3 has bad golden
    sel = 2;
    stalls = 0;
    for (int p = 0; p < 8; p++) begin
      acc = 64'h0;
      for (int i = 0; i < 16; i++) begin
        d = pat(p, i);
        acc = misr_ref(acc, d);
        if (i == 15) begin
          push(2, acc, (p == 3), 1'b0);
          beat(d, 1'b1, (p == 3) ? (acc ^ 64'h1) : acc);
        end else begin
          beat(d, 1'b0, 64'h0);
        end
      end
    end
    if (!tr) stalls++;
`ifndef MISR_BACKPRESSURE_EN
    check("tready_bubbles", 64'(stalls), 64'd8);
`endif
    idle(2);
    check("pkt_cnt_8", 64'(pc[2]), 64'd8);

    // Reset after beat 5 of 16: partial packet dropped, everything cleared
    for (int i = 0; i < 5; i++) beat(pat(9, i), 1'b0, 64'h0);
    tvalid = 1'b0;
    arstn = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    arstn = 1'b1;
    for (int k = 0; k < 3; k++) begin exp_cnt[k] = '0; exp_sticky[k] = 1'b0; end
    @(negedge clk);
    acc = 64'h0;
    for (int i = 0; i < 16; i++) begin
      d = pat(10, i);
      acc = misr_ref(acc, d);
      if (i == 15) begin
        push(2, acc, 1'b0, 1'b0);
        beat(d, 1'b1, acc);
      end else begin
        beat(d, 1'b0, 64'h0);
      end
    end
    idle(2);
    check("pkt_cnt_after_reset", 64'(pc[2]), 64'd1);

    // Drain scoreboard with a bounded wait
    w = 0;
    while (sb.size() != 0 && w < 20) begin w++; @(negedge clk); end
    check("scoreboard_empty", 64'(sb.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
